// File: rtl/layer0_loader_pkg.sv
// Shared widths, types and helpers for the layer-0 input loader.
package layer0_loader_pkg;

    localparam int FEAT_BITS = 2;
    localparam int N_FEAT    = 16;
    localparam int BEAT_FEAT = 4;
    localparam int BEATS     = N_FEAT / BEAT_FEAT;
    localparam int BEAT_W    = BEAT_FEAT * FEAT_BITS;
    localparam int VEC_W     = N_FEAT * FEAT_BITS;

    typedef logic [FEAT_BITS-1:0] feat_t;
    typedef logic [BEAT_W-1:0]    beat_t;
    typedef logic [VEC_W-1:0]     vec_t;

    // Increment an 8-bit event counter, holding at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vec_hold_reg.sv
// Hold register presenting a finished vector to layer 0 with a valid/ready handshake.
module vec_hold_reg #(
    parameter int VEC_W = layer0_loader_pkg::VEC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [VEC_W-1:0] load_vec,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic             out_valid
);

    // Load wins over drain so a same-edge reload keeps out_valid high.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vec   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_vec   <= load_vec;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/layer0_input_loader.sv
// Layer-0 input loader: assembles feature beats into a vector, double-buffered
// through a fill register and a hold register, with framing-error tracking.
module layer0_input_loader #(
    parameter int FEAT_BITS = layer0_loader_pkg::FEAT_BITS,
    parameter int N_FEAT    = layer0_loader_pkg::N_FEAT,
    parameter int BEAT_FEAT = layer0_loader_pkg::BEAT_FEAT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BEAT_FEAT*FEAT_BITS-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    output logic [N_FEAT*FEAT_BITS-1:0]    out_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err_pulse,
    output logic [7:0]                    err_count
);
    import layer0_loader_pkg::sat_inc;

    localparam int BEATS  = N_FEAT / BEAT_FEAT;
    localparam int BEAT_W = BEAT_FEAT * FEAT_BITS;
    localparam int VEC_W  = N_FEAT * FEAT_BITS;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [IDX_W-1:0] beat_idx;
    logic [VEC_W-1:0] fill_vec;
    logic [VEC_W-1:0] merged_vec;
    logic [VEC_W-1:0] load_vec;
    logic             fill_complete;
    logic             accept;
    logic             at_final;
    logic             complete_now;
    logic             early_last;
    logic             missing_last;
    logic             transfer;

    // in_ready comes straight from a flop, so it never depends on in_valid.
    assign in_ready     = !fill_complete;
    assign accept       = in_valid & in_ready;
    assign at_final     = (beat_idx == LAST_IDX);
    assign complete_now = accept & at_final;
    assign early_last   = accept & in_last & !at_final;
    assign missing_last = complete_now & !in_last;
    // A vector finishing this edge bypasses the fill flag straight into the
    // hold register, which gives one-cycle latency and bubble-free streaming.
    assign transfer     = (fill_complete | complete_now) & (!out_valid | out_ready);

    // Fill register with the current beat merged in; source for the hold register.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merged_vec = fill_vec;
        merged_vec[int'(beat_idx)*BEAT_W +: BEAT_W] = in_data;
        load_vec = fill_complete ? fill_vec : merged_vec;
    end

    // Beat counter, fill register and fill-complete flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx      <= '0;
            fill_vec      <= '0;
            fill_complete <= 1'b0;
        end else begin
            if (accept) begin
                fill_vec <= merged_vec;
                if (at_final || in_last) beat_idx <= '0;
                else                     beat_idx <= beat_idx + IDX_W'(1);
            end
            if (transfer)          fill_complete <= 1'b0;
            else if (complete_now) fill_complete <= 1'b1;
        end
    end

    // Framing errors: registered pulse and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= early_last | missing_last;
            if (early_last || missing_last) err_count <= sat_inc(err_count);
        end
    end

    vec_hold_reg #(.VEC_W(VEC_W)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (transfer),
        .load_vec  (load_vec),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid)
    );

endmodule
